// File: rtl/ysyx_22050854_mul_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_22050854_mul_ctrl
//
// Sequencing controller between the EXU and the Booth radix-4 multiplier.
// Decodes RV64M multiply ops into multiplier controls, hands the operands
// over, captures the one-cycle result pulse and holds the selected 64-bit
// result until the consumer takes it. A flush while the multiplier is busy
// is handled by draining its result, because the multiplier cannot abort.
// A one-entry result cache lets a MULH*/MUL pair on identical operands
// answer the second op without another multiply.
//
// Ports:
//   clock, reset             clock, asynchronous active-low reset
//   req_valid / req_ready    EXU request handshake
//   req_op, req_word         funct3[1:0] and MULW flag
//   req_src1, req_src2       rs1 / rs2 values
//   req_tag                  opaque tag echoed on resp_tag
//   flush                    cancel the pending or in-flight op
//   resp_valid / resp_ready  result handshake
//   resp_data, resp_tag      final rd value and its tag
//   mul_valid, mul_flush     multiplier operand valid / flush
//   mul_w, mul_sign          multiplier mulw / mul_signed controls
//   mul_a, mul_b             multiplier operands (latched src1 / src2)
//   mul_rdy                  multiplier ready for operands
//   mul_ovalid               multiplier result pulse
//   mul_hi, mul_lo           multiplier 128-bit product halves
//   busy                     controller is not idle
// ----------------------------------------------------------------------------
module ysyx_22050854_mul_ctrl #(
   parameter int TAG_W    = 5,
   parameter bit REUSE_EN = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic             req_word,
   input  logic [63:0]      req_src1,
   input  logic [63:0]      req_src2,
   input  logic [TAG_W-1:0] req_tag,
   input  logic             flush,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [63:0]      resp_data,
   output logic [TAG_W-1:0] resp_tag,
   output logic             mul_valid,
   output logic             mul_flush,
   output logic             mul_w,
   output logic [1:0]       mul_sign,
   output logic [63:0]      mul_a,
   output logic [63:0]      mul_b,
   input  logic             mul_rdy,
   input  logic             mul_ovalid,
   input  logic [63:0]      mul_hi,
   input  logic [63:0]      mul_lo,
   output logic             busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE,
      S_DRAIN
   } state_t;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;
   localparam logic [1:0] OP_MULHU  = 2'b11;

   // Operand signedness {src1_signed, src2_signed} per op. MUL/MULW only
   // use the low half, which is the same for any signedness.
   function automatic logic [1:0] sign_of(input logic [1:0] op);
      case (op)
         OP_MULHSU: sign_of = 2'b10;
         OP_MULHU:  sign_of = 2'b00;
         OP_MULH:   sign_of = 2'b11;
         default:   sign_of = 2'b11;
      endcase
   endfunction

   state_t             state_q, state_d;

   logic [1:0]         op_q;
   logic               word_q;
   logic [1:0]         sign_q;
   logic [63:0]        src1_q, src2_q;
   logic [TAG_W-1:0]   tag_q;
   logic [63:0]        resp_q;

   logic               cache_vld_q;
   logic [63:0]        cache_src1_q, cache_src2_q;
   logic [1:0]         cache_sign_q;
   logic [63:0]        cache_hi_q, cache_lo_q;

   logic               accept;
   logic [1:0]         req_sign;
   logic               cache_hit;
   logic [63:0]        hit_data;
   logic [63:0]        sel_result;
   logic               capture;

   assign accept   = (state_q == S_IDLE) & req_valid & ~flush;
   assign req_sign = sign_of(req_op);

   // MUL only needs the low half, so any cached signedness serves it; the
   // high-half ops need the exact signedness that produced the entry.
   assign cache_hit = REUSE_EN & cache_vld_q & ~req_word
                    & (req_src1 == cache_src1_q) & (req_src2 == cache_src2_q)
                    & ((req_op == OP_MUL) | (req_sign == cache_sign_q));
   assign hit_data  = (req_op == OP_MUL) ? cache_lo_q : cache_hi_q;

   // MULW is re-extended here so the result does not depend on how the
   // multiplier extends its own word product.
   assign sel_result = word_q            ? {{32{mul_lo[31]}}, mul_lo[31:0]} :
                       (op_q == OP_MUL) ? mul_lo : mul_hi;

   // A result pulse coinciding with flush belongs to the cancelled op.
   assign capture = (state_q == S_WAIT) & mul_ovalid & ~flush;

   // NOTE: every signal assigned in always_comb gets a default first so no
   // path leaves it unassigned and infers a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) state_d = cache_hit ? S_DONE : S_ISSUE;
         end
         S_ISSUE: begin
            if (flush)        state_d = S_IDLE;
            else if (mul_rdy) state_d = S_WAIT;
         end
         S_WAIT: begin
            // If the result arrives with the flush, nothing is left to drain.
            if (flush)           state_d = mul_ovalid ? S_IDLE : S_DRAIN;
            else if (mul_ovalid) state_d = S_DONE;
         end
         S_DRAIN: begin
            if (mul_ovalid) state_d = S_IDLE;
         end
         S_DONE: begin
            if (flush | resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         op_q   <= OP_MUL;
         word_q <= 1'b0;
         sign_q <= 2'b00;
         src1_q <= '0;
         src2_q <= '0;
         tag_q  <= '0;
         resp_q <= '0;
      end else begin
         if (accept) begin
            op_q   <= req_op;
            word_q <= req_word;
            sign_q <= req_sign;
            src1_q <= req_src1;
            src2_q <= req_src2;
            tag_q  <= req_tag;
            if (cache_hit) resp_q <= hit_data;
         end
         if (capture) resp_q <= sel_result;
      end
   end

   // Word products are not cached: their low half is truncated/re-extended
   // and the high half is meaningless, so they cannot serve later ops.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cache_vld_q  <= 1'b0;
         cache_src1_q <= '0;
         cache_src2_q <= '0;
         cache_sign_q <= 2'b00;
         cache_hi_q   <= '0;
         cache_lo_q   <= '0;
      end else if (REUSE_EN && capture && !word_q) begin
         cache_vld_q  <= 1'b1;
         cache_src1_q <= src1_q;
         cache_src2_q <= src2_q;
         cache_sign_q <= sign_q;
         cache_hi_q   <= mul_hi;
         cache_lo_q   <= mul_lo;
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign resp_valid = (state_q == S_DONE);
   assign resp_data  = resp_q;
   assign resp_tag   = tag_q;

   // Withholding mul_valid during a flush keeps a same-cycle mul_rdy from
   // starting a multiply that the controller has already abandoned.
   assign mul_valid  = (state_q == S_ISSUE) & ~flush;
   assign mul_flush  = flush & (state_q == S_WAIT);
   assign mul_w      = word_q;
   assign mul_sign   = sign_q;
   assign mul_a      = src1_q;
   assign mul_b      = src2_q;

endmodule

// File: tb/tb_ysyx_22050854_mul_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22050854_mul_ctrl
//
// Directed bench for the multiply controller. A behavioural multiplier
// (fixed latency, cannot abort) answers issued operands; each scenario task
// drives requests and compares against hand-computed values.
// ----------------------------------------------------------------------------
module tb_ysyx_22050854_mul_ctrl;

   localparam int TAG_W = 5;
   localparam int LAT   = 8;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [1:0]       req_op = 2'b00;
   logic             req_word = 1'b0;
   logic [63:0]      req_src1 = '0;
   logic [63:0]      req_src2 = '0;
   logic [TAG_W-1:0] req_tag = '0;
   logic             flush = 1'b0;
   logic             resp_valid;
   logic             resp_ready = 1'b0;
   logic [63:0]      resp_data;
   logic [TAG_W-1:0] resp_tag;
   logic             mul_valid;
   logic             mul_flush;
   logic             mul_w;
   logic [1:0]       mul_sign;
   logic [63:0]      mul_a;
   logic [63:0]      mul_b;
   logic             mul_rdy;
   logic             mul_ovalid;
   logic [63:0]      mul_hi;
   logic [63:0]      mul_lo;
   logic             busy;

   int n_cmp = 0;
   int n_err = 0;

   ysyx_22050854_mul_ctrl #(.TAG_W(TAG_W), .REUSE_EN(1'b1)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_word   (req_word),
      .req_src1   (req_src1),
      .req_src2   (req_src2),
      .req_tag    (req_tag),
      .flush      (flush),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_tag   (resp_tag),
      .mul_valid  (mul_valid),
      .mul_flush  (mul_flush),
      .mul_w      (mul_w),
      .mul_sign   (mul_sign),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_rdy    (mul_rdy),
      .mul_ovalid (mul_ovalid),
      .mul_hi     (mul_hi),
      .mul_lo     (mul_lo),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   // ---------------- behavioural multiplier ----------------
   logic       mdl_busy;
   int         mdl_cnt;
   int         issue_cnt;
   int         mv_cycles;
   logic [1:0] last_sign;
   logic       last_w;

   assign mul_rdy = ~mdl_busy;

   function automatic logic [127:0] product(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] s, input logic w);
      logic [127:0] ea, eb;
      if (w) begin
         ea = {{96{a[31]}}, a[31:0]};
         eb = {{96{b[31]}}, b[31:0]};
      end else begin
         ea = s[1] ? {{64{a[63]}}, a} : {64'd0, a};
         eb = s[0] ? {{64{b[63]}}, b} : {64'd0, b};
      end
      return ea * eb;
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         mdl_busy   <= 1'b0;
         mdl_cnt    <= 0;
         mul_ovalid <= 1'b0;
         mul_hi     <= '0;
         mul_lo     <= '0;
         issue_cnt  <= 0;
         mv_cycles  <= 0;
         last_sign  <= 2'b00;
         last_w     <= 1'b0;
      end else begin
         mul_ovalid <= 1'b0;
         if (mul_valid) mv_cycles <= mv_cycles + 1;
         if (mdl_busy) begin
            if (mdl_cnt == 1) begin
               mul_ovalid <= 1'b1;
               mdl_busy   <= 1'b0;
            end
            mdl_cnt <= mdl_cnt - 1;
         end else if (mul_valid && mul_rdy) begin
            mdl_busy           <= 1'b1;
            mdl_cnt            <= LAT;
            {mul_hi, mul_lo}   <= product(mul_a, mul_b, mul_sign, mul_w);
            issue_cnt          <= issue_cnt + 1;
            last_sign          <= mul_sign;
            last_w             <= mul_w;
         end
      end
   end

   // ---------------- drive helpers (no comparisons) ----------------
   task automatic do_req(input logic [1:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [TAG_W-1:0] tag, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         req_valid = 1'b1;
         req_op    = op;
         req_word  = w;
         req_src1  = a;
         req_src2  = b;
         req_tag   = tag;
         @(posedge clock);
         #1 req_valid = 1'b0;
      end
   endtask

   // Cycles counted in negedges after the accepting edge.
   task automatic get_resp(input int max, output bit ok, output int cyc);
      ok  = 1'b0;
      cyc = 0;
      for (int i = 0; i < max; i++) begin
         @(negedge clock);
         cyc++;
         if (resp_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic take_resp();
      resp_ready = 1'b1;
      @(posedge clock);
      #1 resp_ready = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      #1;
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
      n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
      n_cmp++; if (mul_valid !== 1'b0) begin n_err++; $display("FAIL reset_mul_valid got %b exp 0", mul_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_cmp++; if ({mul_sign, mul_w} !== 3'b000) begin n_err++; $display("FAIL reset_mul_ctrl got %b exp 000", {mul_sign, mul_w}); end
      n_cmp++; if (resp_data !== 64'd0) begin n_err++; $display("FAIL reset_resp_data got %h exp 0", resp_data); end
   endtask

   task automatic test_mul();
      bit ok; int cyc;
      do_req(2'b00, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd7, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL mul_accept got timeout exp accept"); end
      get_resp(40, ok, cyc);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL mul_resp got timeout exp resp_valid"); end
      n_cmp++; if (cyc !== LAT + 3) begin n_err++; $display("FAIL mul_latency got %0d exp %0d", cyc, LAT + 3); end
      n_cmp++; if (last_sign !== 2'b11) begin n_err++; $display("FAIL mul_sign got %b exp 11", last_sign); end
      n_cmp++; if (resp_data !== 64'hFFFF_FFFF_FFFF_FFF1) begin n_err++; $display("FAIL mul_data got %h exp fffffffffffffff1", resp_data); end
      n_cmp++; if (resp_tag !== 5'd7) begin n_err++; $display("FAIL mul_tag got %0d exp 7", resp_tag); end
      take_resp();
   endtask

   task automatic test_mulhu_mulh();
      bit ok; int cyc; int ic;
      do_req(2'b11, 1'b0, '1, '1, 5'd1, ok);
      get_resp(40, ok, cyc);
      n_cmp++; if (!ok || resp_data !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL mulhu_data got %h ok %b exp fffffffffffffffe", resp_data, ok); end
      n_cmp++; if (last_sign !== 2'b00) begin n_err++; $display("FAIL mulhu_sign got %b exp 00", last_sign); end
      take_resp();
      ic = issue_cnt;
      do_req(2'b01, 1'b0, '1, '1, 5'd2, ok);
      get_resp(40, ok, cyc);
      n_cmp++; if (!ok || resp_data !== 64'd0) begin n_err++; $display("FAIL mulh_data got %h ok %b exp 0", resp_data, ok); end
      n_cmp++; if (issue_cnt !== ic + 1) begin n_err++; $display("FAIL mulh_issued got %0d exp %0d", issue_cnt, ic + 1); end
      take_resp();
   endtask

   task automatic test_mulhsu();
      bit ok; int cyc;
      do_req(2'b10, 1'b0, '1, '1, 5'd3, ok);
      get_resp(40, ok, cyc);
      n_cmp++; if (last_sign !== 2'b10) begin n_err++; $display("FAIL mulhsu_sign got %b exp 10", last_sign); end
      n_cmp++; if (!ok || resp_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL mulhsu_data got %h ok %b exp ffffffffffffffff", resp_data, ok); end
      take_resp();
   endtask

   task automatic test_mulw();
      bit ok; int cyc;
      do_req(2'b00, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd4, ok);
      get_resp(40, ok, cyc);
      n_cmp++; if (last_w !== 1'b1) begin n_err++; $display("FAIL mulw_w got %b exp 1", last_w); end
      n_cmp++; if (!ok || resp_data !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL mulw_data got %h ok %b exp fffffffffffffffe", resp_data, ok); end
      take_resp();
   endtask

   task automatic test_reuse();
      bit ok; int cyc; int mv;
      do_req(2'b01, 1'b0, 64'h4000_0000_0000_0000, 64'd4, 5'd5, ok);
      get_resp(40, ok, cyc);
      n_cmp++; if (!ok || resp_data !== 64'd1) begin n_err++; $display("FAIL reuse_mulh got %h ok %b exp 1", resp_data, ok); end
      take_resp();
      mv = mv_cycles;
      do_req(2'b00, 1'b0, 64'h4000_0000_0000_0000, 64'd4, 5'd6, ok);
      get_resp(40, ok, cyc);
      n_cmp++; if (!ok || cyc !== 1) begin n_err++; $display("FAIL reuse_latency got %0d ok %b exp 1", cyc, ok); end
      n_cmp++; if (resp_data !== 64'd0) begin n_err++; $display("FAIL reuse_data got %h exp 0", resp_data); end
      n_cmp++; if (resp_tag !== 5'd6) begin n_err++; $display("FAIL reuse_tag got %0d exp 6", resp_tag); end
      n_cmp++; if (mv_cycles !== mv) begin n_err++; $display("FAIL reuse_no_issue got %0d exp %0d", mv_cycles, mv); end
      take_resp();
   endtask

   task automatic test_flush_idle();
      int ic;
      ic = issue_cnt;
      @(negedge clock);
      req_valid = 1'b1; req_op = 2'b00; req_word = 1'b0;
      req_src1 = 64'd9; req_src2 = 64'd9; req_tag = 5'd9;
      flush = 1'b1;
      @(posedge clock);
      #1 req_valid = 1'b0; flush = 1'b0;
      n_cmp++; if (busy !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL flush_idle_state got busy %b ready %b exp 0 1", busy, req_ready); end
      repeat (3) @(negedge clock);
      n_cmp++; if (issue_cnt !== ic) begin n_err++; $display("FAIL flush_idle_issue got %0d exp %0d", issue_cnt, ic); end
   endtask

   task automatic test_flush_wait();
      bit ok; bit seen_ov; bit seen_resp; int cyc;
      do_req(2'b00, 1'b0, 64'd5, 64'd7, 5'd10, ok);
      repeat (4) @(negedge clock);        // ISSUE, then 3 cycles into WAIT
      flush = 1'b1;
      #1;
      n_cmp++; if (mul_flush !== 1'b1) begin n_err++; $display("FAIL flush_mul_flush got %b exp 1", mul_flush); end
      @(negedge clock);
      flush = 1'b0;
      seen_ov = 1'b0; seen_resp = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (resp_valid) seen_resp = 1'b1;
         if (mul_ovalid) begin
            seen_ov = 1'b1;
            n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL drain_ready_early got %b exp 0", req_ready); end
            @(negedge clock);
            n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL drain_ready_after got %b exp 1", req_ready); end
            break;
         end
         @(negedge clock);
      end
      n_cmp++; if (!seen_ov) begin n_err++; $display("FAIL drain_ovalid got timeout exp pulse"); end
      n_cmp++; if (seen_resp || resp_valid) begin n_err++; $display("FAIL drain_no_resp got resp_valid exp none"); end
      do_req(2'b00, 1'b0, 64'd2, 64'd3, 5'd11, ok);
      get_resp(40, ok, cyc);
      n_cmp++; if (!ok || resp_data !== 64'd6 || resp_tag !== 5'd11) begin n_err++; $display("FAIL post_flush_mul got %h tag %0d ok %b exp 6 tag 11", resp_data, resp_tag, ok); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         n_cmp++; if (resp_valid !== 1'b1 || resp_data !== 64'd6) begin n_err++; $display("FAIL hold_stable got valid %b data %h exp 1 6", resp_valid, resp_data); end
      end
      take_resp();
      #1;
      n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL release got valid %b ready %b exp 0 1", resp_valid, req_ready); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      repeat (3) @(negedge clock);
      test_reset();
      reset = 1'b1;
      test_mul();
      test_mulhu_mulh();
      test_mulhsu();
      test_mulw();
      test_reuse();
      test_flush_idle();
      test_flush_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ysyx_22050854_mul_ctrl.md
Name: ysyx_22050854_mul_ctrl

Overview:
Sequencing controller between the EXU and the Booth radix-4 multiplier. It decodes RV64M multiply ops (MUL/MULH/MULHSU/MULHU/MULW) into multiplier controls, handshakes operands in, captures the one-cycle result pulse and holds the selected 64-bit result until the consumer takes it. It handles pipeline flush by draining the in-flight multiply, because the multiplier does not abort. A one-entry result cache lets a MULH*/MUL pair on identical operands skip the second multiply.

Parameters:
TAG_W, 5, width of the opaque request tag (rd index) carried to the response
REUSE_EN, 1, 1 enables the one-entry result cache; 0 makes every request issue to the multiplier

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
req_valid  in  1  EXU request valid
req_ready  out  1  controller can accept a request
req_op  in  2  funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
req_word  in  1  1 = MULW (only legal with req_op 00)
req_src1  in  64  rs1 value
req_src2  in  64  rs2 value
req_tag  in  TAG_W  tag returned with the result
flush  in  1  cancel the pending or in-flight op
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts the result
resp_data  out  64  final rd value
resp_tag  out  TAG_W  tag of the result
mul_valid  out  1  to multiplier: operands valid
mul_flush  out  1  to multiplier flush; equals flush & (state==WAIT)
mul_w  out  1  to multiplier mulw
mul_sign  out  2  to multiplier mul_signed
mul_a  out  64  to multiplier multiplicand (= latched src1)
mul_b  out  64  to multiplier multiplier (= latched src2)
mul_rdy  in  1  multiplier mul_ready
mul_ovalid  in  1  multiplier out_valid (one-cycle pulse)
mul_hi  in  64  multiplier result_hi
mul_lo  in  64  multiplier result_lo
busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0 except req_ready=1; cache invalid.
- Sign map: MUL and MULW→11, MULH→11, MULHSU→10 (src1 signed, src2 unsigned), MULHU→00.
- Result select: MUL→mul_lo; MULH/MULHSU/MULHU→mul_hi; MULW→{32{mul_lo[31]},mul_lo[31:0]}, re-extended locally regardless of the multiplier's own extension.
- States: IDLE, ISSUE, WAIT, DONE, DRAIN. req_ready=1 only in IDLE.
- IDLE: on req_valid & ~flush, latch op/word/srcs/tag. If a cache hit occurs, go to DONE with resp_data taken from the cache. Otherwise go to ISSUE. If flush is asserted in the same cycle, the request is not accepted.
- ISSUE: mul_valid=1 with stable mul_a/mul_b/mul_w/mul_sign. When mul_rdy=1, go to WAIT; mul_valid drops the next cycle. On flush, go to IDLE without issuing.
- WAIT: on mul_ovalid, capture the selected result into the response register and go to DONE. For non-word ops, also fill the cache. On flush, go to DRAIN; a mul_ovalid in the same cycle as flush is discarded.
- DRAIN: wait for mul_ovalid and discard it (no response, no cache fill), then go to IDLE.
- DONE: resp_valid=1; resp_data and resp_tag stay stable until resp_ready, then go to IDLE. A new request is accepted no earlier than the following cycle. On flush, resp_valid drops and the state goes to IDLE.
- Cache: key {src1,src2,sign}, stores hi and lo.
  - Hit requires: REUSE_EN, valid entry, ~req_word, src1 and src2 equal to the key, and (req_op==MUL or mapped sign == stored sign).
  - Hit latency: resp_valid one cycle after the accept; mul_valid never asserts.
- Latency without a hit: accept→ISSUE is 1 cycle; WAIT→DONE occurs the cycle after mul_ovalid.
- Only one operation is outstanding at a time. Reset mid-operation returns the controller to IDLE immediately; the multiplier reset is external.

Test Plan:
- MUL src1=3, src2=0xFFFFFFFFFFFFFFFB → mul_sign=11, resp_data=0xFFFFFFFFFFFFFFF1, tag echoed.
- MULHU then MULH with src1=src2=0xFFFFFFFFFFFFFFFF → 0xFFFFFFFFFFFFFFFE then 0x0; the second op issues (sign mismatch).
- MULHSU src1=0xFFFFFFFFFFFFFFFF, src2=0xFFFFFFFFFFFFFFFF → mul_sign=10, resp_data=0xFFFFFFFFFFFFFFFF.
- MULW src1=0x7FFFFFFF, src2=2 → mul_w=1, resp_data=0xFFFFFFFFFFFFFFFE.
- MULH src1=0x4000000000000000, src2=4, then MUL on the same operands → 0x1 then 0x0; the MUL response arrives 1 cycle after accept with no mul_valid pulse.
- Flush 3 cycles into WAIT → no resp_valid; the subsequent mul_ovalid is ignored; req_ready=1 the cycle after it; the next MUL 2×3 returns 6. Also hold resp_ready=0 for 5 cycles in DONE → resp_data stays stable.
